spell_mem_arbiter: RTL and testbench

//   Two-requester round-robin arbiter and sequencer for the shared spell memory

---
 rtl/spell_mem_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_spell_mem_arbiter.sv | 395 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spell_mem_arbiter.sv
// ---------------------------------------------------------------------------
// spell_mem_arbiter
//
// Purpose:
//   Round-robin arbiter and access sequencer for the single shared spell
//   memory port. Port A is the CPU core (fetch/load/store), port B is the
//   debug/programming interface. One request is latched at a time, memory
//   select is held until the memory reports data_ready, the result is
//   returned to the owner with a one-cycle ack, and select is then dropped
//   for one cycle so the memory can clear data_ready. A watchdog aborts any
//   access that waits TIMEOUT cycles without data_ready.
//
// Parameters:
//   TIMEOUT        max cycles spent waiting for mem_ready (2..255)
//
// Ports:
//   clk, rst_n     clock, synchronous active-low reset
//   a_req          port A request (level, held until a_ack)
//   a_addr         port A address
//   a_type_data    port A memory select: 1 = data memory, 0 = code memory
//   a_write        port A direction: 1 = write, 0 = read
//   a_wdata        port A write data
//   a_ack          port A completion pulse (one cycle)
//   a_rdata        port A read data, valid while a_ack = 1, else 0
//   a_err          port A timeout flag, valid while a_ack = 1, else 0
//   b_*            identical set for port B
//   mem_select     memory select
//   mem_addr       memory address
//   mem_type_data  memory type (data/code)
//   mem_write      memory write strobe
//   mem_wdata      memory write data
//   mem_rdata      memory read data
//   mem_ready      memory data_ready
//   busy           high whenever the sequencer is not idle
//   grant_b        owner of the current/last access (0 = A, 1 = B)
// ---------------------------------------------------------------------------
module spell_mem_arbiter #(
  parameter int TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst_n,

  input  logic       a_req,
  input  logic [7:0] a_addr,
  input  logic       a_type_data,
  input  logic       a_write,
  input  logic [7:0] a_wdata,
  output logic       a_ack,
  output logic [7:0] a_rdata,
  output logic       a_err,

  input  logic       b_req,
  input  logic [7:0] b_addr,
  input  logic       b_type_data,
  input  logic       b_write,
  input  logic [7:0] b_wdata,
  output logic       b_ack,
  output logic [7:0] b_rdata,
  output logic       b_err,

  output logic       mem_select,
  output logic [7:0] mem_addr,
  output logic       mem_type_data,
  output logic       mem_write,
  output logic [7:0] mem_wdata,
  input  logic [7:0] mem_rdata,
  input  logic       mem_ready,

  output logic       busy,
  output logic       grant_b
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RELEASE = 2'd2
  } state_t;

  // Watchdog fires when the counter reaches this value while still waiting.
  localparam logic [7:0] LAST_COUNT = 8'(TIMEOUT - 1);

  state_t     state;
  logic       last_grant;
  logic [7:0] counter;

  logic       pick_b;
  logic       timeout_hit;
  logic       finish;
  logic [7:0] ret_data;
  logic       ret_err;

  // Round-robin choice: B wins when it is the only requester, or when both
  // request and A was served last. last_grant resets to B so A wins the
  // first tie after reset.
  assign pick_b = b_req & (~a_req | ~last_grant);

  // Completion of an access. mem_ready takes priority over the watchdog, so
  // data arriving in the final allowed cycle is still returned without error.
  // Writes return 0 as read data.
  always_comb begin
    timeout_hit = (counter == LAST_COUNT);
    finish      = mem_ready | timeout_hit;
    ret_err     = ~mem_ready;
    ret_data    = 8'h00;
    if (mem_ready && !mem_write) begin
      ret_data = mem_rdata;
    end
  end

  // Sequencer: IDLE grants and latches a request, ACCESS holds the memory
  // interface stable until ready or timeout, RELEASE keeps select low for
  // exactly one cycle. Ack/rdata/err are pulses, cleared every cycle unless
  // an access completes, so they read as 0 whenever ack is low.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      last_grant    <= 1'b1;
      counter       <= 8'h00;
      a_ack         <= 1'b0;
      a_rdata       <= 8'h00;
      a_err         <= 1'b0;
      b_ack         <= 1'b0;
      b_rdata       <= 8'h00;
      b_err         <= 1'b0;
      mem_select    <= 1'b0;
      mem_addr      <= 8'h00;
      mem_type_data <= 1'b0;
      mem_write     <= 1'b0;
      mem_wdata     <= 8'h00;
      busy          <= 1'b0;
      grant_b       <= 1'b0;
    end else begin
      a_ack   <= 1'b0;
      a_rdata <= 8'h00;
      a_err   <= 1'b0;
      b_ack   <= 1'b0;
      b_rdata <= 8'h00;
      b_err   <= 1'b0;

      case (state)
        IDLE: begin
          if (a_req || b_req) begin
            grant_b       <= pick_b;
            last_grant    <= pick_b;
            mem_addr      <= pick_b ? b_addr      : a_addr;
            mem_type_data <= pick_b ? b_type_data : a_type_data;
            mem_write     <= pick_b ? b_write     : a_write;
            mem_wdata     <= pick_b ? b_wdata     : a_wdata;
            mem_select    <= 1'b1;
            counter       <= 8'h00;
            busy          <= 1'b1;
            state         <= ACCESS;
          end
        end

        ACCESS: begin
          if (finish) begin
            if (grant_b) begin
              b_ack   <= 1'b1;
              b_rdata <= ret_data;
              b_err   <= ret_err;
            end else begin
              a_ack   <= 1'b1;
              a_rdata <= ret_data;
              a_err   <= ret_err;
            end
            mem_select <= 1'b0;
            state      <= RELEASE;
          end else begin
            counter <= counter + 8'd1;
          end
        end

        RELEASE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          mem_select <= 1'b0;
          busy       <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spell_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_spell_mem_arbiter
//
// Purpose:
//   Scoreboard bench for spell_mem_arbiter. A behavioural spell memory with
//   programmable response delay sits on the memory port. Each batch of
//   requests is predicted at transaction level (grant order, ack cycle,
//   returned data, error flag) and pushed to a queue; an independent monitor
//   pops one entry per ack and compares.
// ---------------------------------------------------------------------------
module tb_spell_mem_arbiter;

  localparam int TO       = 15;
  localparam int MEM_SIZE = 32;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       a_req = 1'b0;
  logic [7:0] a_addr = 8'h00;
  logic       a_type_data = 1'b0;
  logic       a_write = 1'b0;
  logic [7:0] a_wdata = 8'h00;
  logic       a_ack;
  logic [7:0] a_rdata;
  logic       a_err;

  logic       b_req = 1'b0;
  logic [7:0] b_addr = 8'h00;
  logic       b_type_data = 1'b0;
  logic       b_write = 1'b0;
  logic [7:0] b_wdata = 8'h00;
  logic       b_ack;
  logic [7:0] b_rdata;
  logic       b_err;

  logic       mem_select;
  logic [7:0] mem_addr;
  logic       mem_type_data;
  logic       mem_write;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata = 8'h00;
  logic       mem_ready = 1'b0;
  logic       busy;
  logic       grant_b;

  typedef struct {
    logic [7:0] addr;
    logic       type_data;
    logic       write;
    logic [7:0] wdata;
  } req_t;

  typedef struct {
    bit         port_b;
    logic [7:0] rdata;
    bit         err;
    int         ack_cyc;
  } exp_t;

  req_t a_list[$];
  req_t b_list[$];
  exp_t exp_q[$];
  exp_t mon_e;

  int n_compared = 0;
  int n_failed   = 0;
  int cyc        = 0;

  spell_mem_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_addr(a_addr), .a_type_data(a_type_data),
    .a_write(a_write), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_rdata(a_rdata), .a_err(a_err),
    .b_req(b_req), .b_addr(b_addr), .b_type_data(b_type_data),
    .b_write(b_write), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_rdata(b_rdata), .b_err(b_err),
    .mem_select(mem_select), .mem_addr(mem_addr),
    .mem_type_data(mem_type_data), .mem_write(mem_write),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .busy(busy), .grant_b(grant_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural spell memory: raises ready mem_delay cycles after it first
  // sees select, never when stuck; clears ready once select drops.
  logic [7:0] code_mem [MEM_SIZE];
  logic [7:0] data_mem [MEM_SIZE];
  int         mem_delay = 0;
  bit         mem_stuck = 1'b0;
  int         mem_cnt = 0;

  always @(posedge clk) begin
    if (!mem_select) begin
      mem_ready <= 1'b0;
      mem_cnt   <= 0;
    end else if (!mem_ready) begin
      if (!mem_stuck && mem_cnt == mem_delay) begin
        mem_ready <= 1'b1;
        if (mem_write) begin
          if (mem_addr < 8'(MEM_SIZE)) begin
            if (mem_type_data) data_mem[mem_addr[4:0]] = mem_wdata;
            else               code_mem[mem_addr[4:0]] = mem_wdata;
          end
          mem_rdata <= 8'hEE;
        end else if (mem_addr < 8'(MEM_SIZE)) begin
          mem_rdata <= mem_type_data ? data_mem[mem_addr[4:0]]
                                     : code_mem[mem_addr[4:0]];
        end else begin
          mem_rdata <= 8'h00;
        end
      end else begin
        mem_cnt <= mem_cnt + 1;
      end
    end
  end

  // Reference model state
  logic [7:0] ref_code [MEM_SIZE];
  logic [7:0] ref_data [MEM_SIZE];
  bit         ref_last_b = 1'b1;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req_v);
    n_compared++;
    if (act !== req_v) begin
      n_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)",
               name, act, req_v, cyc);
    end
  endtask

  function automatic logic [7:0] ref_read(input req_t r);
    if (r.addr >= 8'(MEM_SIZE)) return 8'h00;
    return r.type_data ? ref_data[r.addr[4:0]] : ref_code[r.addr[4:0]];
  endfunction

  // Transaction-level prediction: every queued request stays pending (each
  // port re-presents its next request right after its ack), so grants go in
  // round-robin order when both lists are non-empty. An access granted at
  // cycle t completes at t + min(2 + delay, TO) and the next grant follows
  // two cycles after that completion.
  task automatic predict(input int e0, input int d, input bit stuck);
    int ia = 0;
    int ib = 0;
    int t  = e0;
    while (ia < a_list.size() || ib < b_list.size()) begin
      bit   use_b;
      bit   tmo;
      int   rel;
      req_t r;
      exp_t e;
      if (ia < a_list.size() && ib < b_list.size()) use_b = !ref_last_b;
      else                                           use_b = (ib < b_list.size());
      if (use_b) begin r = b_list[ib]; ib++; end
      else       begin r = a_list[ia]; ia++; end
      ref_last_b = use_b;
      tmo = stuck || (2 + d > TO);
      rel = tmo ? TO : 2 + d;
      e.port_b  = use_b;
      e.err     = tmo;
      e.ack_cyc = t + rel;
      e.rdata   = 8'h00;
      if (!r.write && !tmo) e.rdata = ref_read(r);
      if (r.write && !stuck && (1 + d <= rel) && r.addr < 8'(MEM_SIZE)) begin
        if (r.type_data) ref_data[r.addr[4:0]] = r.wdata;
        else             ref_code[r.addr[4:0]] = r.wdata;
      end
      exp_q.push_back(e);
      t = t + rel + 2;
    end
  endtask

  task automatic drive_a(input req_t r);
    a_addr = r.addr; a_type_data = r.type_data;
    a_write = r.write; a_wdata = r.wdata; a_req = 1'b1;
  endtask

  task automatic drive_b(input req_t r);
    b_addr = r.addr; b_type_data = r.type_data;
    b_write = r.write; b_wdata = r.wdata; b_req = 1'b1;
  endtask

  function automatic req_t mk_req(input int addr, input bit td, input bit wr,
                                  input int wd);
    req_t r;
    r.addr = 8'(addr); r.type_data = td; r.write = wr; r.wdata = 8'(wd);
    return r;
  endfunction

  function automatic req_t rand_req();
    return mk_req($urandom_range(0, 39), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), $urandom_range(0, 255));
  endfunction

  // Issues the queued requests of both ports, predicts them, and follows
  // the requester protocol: on each ack present the next request or drop req.
  task automatic apply_stimulus(input int d, input bit stuck);
    int na = a_list.size();
    int nb = b_list.size();
    int ia = 0;
    int ib = 0;
    int budget;
    mem_delay = d;
    mem_stuck = stuck;
    @(negedge clk);
    predict(cyc + 1, d, stuck);
    if (na > 0) drive_a(a_list[0]);
    if (nb > 0) drive_b(b_list[0]);
    budget = (na + nb) * (TO + 4) + 10;
    while ((ia < na || ib < nb) && budget > 0) begin
      @(negedge clk);
      budget--;
      if (a_ack) begin
        ia++;
        if (ia < na) drive_a(a_list[ia]); else a_req = 1'b0;
      end
      if (b_ack) begin
        ib++;
        if (ib < nb) drive_b(b_list[ib]); else b_req = 1'b0;
      end
    end
    n_compared++;
    if (budget == 0) begin
      n_failed++;
      $display("[TB] FAIL batch_timeout: acks seen A=%0d B=%0d, expected A=%0d B=%0d",
               ia, ib, na, nb);
      a_req = 1'b0;
      b_req = 1'b0;
      exp_q.delete();
    end
    a_list.delete();
    b_list.delete();
    @(negedge clk);
  endtask

  task automatic check_output_zero(input string tag);
    check({tag, "_a_ack"}, 32'(a_ack), 0);
    check({tag, "_a_rdata"}, 32'(a_rdata), 0);
    check({tag, "_a_err"}, 32'(a_err), 0);
    check({tag, "_b_ack"}, 32'(b_ack), 0);
    check({tag, "_b_rdata"}, 32'(b_rdata), 0);
    check({tag, "_b_err"}, 32'(b_err), 0);
    check({tag, "_mem_select"}, 32'(mem_select), 0);
    check({tag, "_mem_addr"}, 32'(mem_addr), 0);
    check({tag, "_mem_type"}, 32'(mem_type_data), 0);
    check({tag, "_mem_write"}, 32'(mem_write), 0);
    check({tag, "_mem_wdata"}, 32'(mem_wdata), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_grant_b"}, 32'(grant_b), 0);
  endtask

  // Aborts a read that is waiting on a silent memory by pulling reset.
  task automatic reset_mid_access();
    mem_stuck = 1'b1;
    @(negedge clk);
    drive_a(mk_req(3, 1'b0, 1'b0, 0));
    @(negedge clk);
    @(negedge clk);
    check("abort_busy", 32'(busy), 1);
    check("abort_select", 32'(mem_select), 1);
    rst_n = 1'b0;
    @(negedge clk);
    check_output_zero("abort_rst");
    a_req = 1'b0;
    rst_n = 1'b1;
    ref_last_b = 1'b1;
    @(negedge clk);
  endtask

  // Monitor: per-cycle invariants plus one scoreboard entry per ack.
  always @(negedge clk) begin
    check("ack_exclusive", 32'(a_ack & b_ack), 0);
    if (!a_ack) check("a_quiet", {23'b0, a_rdata, a_err}, 0);
    if (!b_ack) check("b_quiet", {23'b0, b_rdata, b_err}, 0);
    if (a_ack || b_ack) begin
      n_compared++;
      if (exp_q.size() == 0) begin
        n_failed++;
        $display("[TB] FAIL unexpected_ack: got a_ack=%0b b_ack=%0b, expected none",
                 a_ack, b_ack);
      end else begin
        mon_e = exp_q.pop_front();
        check("ack_port", 32'(b_ack), 32'(mon_e.port_b));
        check("grant_b", 32'(grant_b), 32'(mon_e.port_b));
        check("ack_cycle", 32'(cyc), 32'(mon_e.ack_cyc));
        check("rdata", 32'(b_ack ? b_rdata : a_rdata), 32'(mon_e.rdata));
        check("err", 32'(b_ack ? b_err : a_err), 32'(mon_e.err));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL global_watchdog: simulation still running at %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int sel;
    int d;
    bit stuck;
    int na;
    int nb;

    for (int i = 0; i < MEM_SIZE; i++) begin
      code_mem[i] = 8'(i * 5 + 1);
      data_mem[i] = 8'(i * 9 + 2);
    end
    code_mem[5] = 8'h3C;
    for (int i = 0; i < MEM_SIZE; i++) begin
      ref_code[i] = 8'(i * 5 + 1);
      ref_data[i] = 8'(i * 9 + 2);
    end
    ref_code[5] = 8'h3C;

    $display("[TB] reset");
    repeat (3) @(negedge clk);
    check_output_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] A read code[5]");
    a_list.push_back(mk_req(5, 1'b0, 1'b0, 0));
    apply_stimulus(0, 1'b0);

    $display("[TB] B write data[2], A read data[2]");
    b_list.push_back(mk_req(2, 1'b1, 1'b1, 8'hA5));
    a_list.push_back(mk_req(2, 1'b1, 1'b0, 0));
    apply_stimulus(0, 1'b0);

    $display("[TB] reset during access");
    reset_mid_access();

    $display("[TB] both ports held for four accesses");
    for (int i = 0; i < 2; i++) begin
      a_list.push_back(rand_req());
      b_list.push_back(rand_req());
    end
    apply_stimulus(0, 1'b0);

    $display("[TB] slow memory and timeout");
    a_list.push_back(mk_req(7, 1'b0, 1'b0, 0));
    apply_stimulus(3, 1'b0);
    b_list.push_back(mk_req(9, 1'b1, 1'b0, 0));
    apply_stimulus(0, 1'b1);
    b_list.push_back(mk_req(9, 1'b1, 1'b1, 8'h77));
    apply_stimulus(0, 1'b1);
    a_list.push_back(mk_req(9, 1'b1, 1'b0, 0));
    apply_stimulus(0, 1'b0);

    $display("[TB] ready versus watchdog boundary");
    a_list.push_back(mk_req(11, 1'b0, 1'b0, 0));
    apply_stimulus(TO - 2, 1'b0);
    b_list.push_back(mk_req(12, 1'b0, 1'b0, 0));
    apply_stimulus(TO - 1, 1'b0);
    a_list.push_back(mk_req(13, 1'b1, 1'b1, 8'h5A));
    apply_stimulus(TO - 1, 1'b0);
    b_list.push_back(mk_req(13, 1'b1, 1'b0, 0));
    apply_stimulus(0, 1'b0);

    $display("[TB] out-of-range address");
    a_list.push_back(mk_req(200, 1'b1, 1'b0, 0));
    apply_stimulus(0, 1'b0);

    $display("[TB] random batches");
    for (int n = 0; n < 40; n++) begin
      na = $urandom_range(0, 2);
      nb = $urandom_range(0, 2);
      if (na == 0 && nb == 0) na = 1;
      for (int i = 0; i < na; i++) a_list.push_back(rand_req());
      for (int i = 0; i < nb; i++) b_list.push_back(rand_req());
      sel   = $urandom_range(0, 9);
      stuck = 1'b0;
      if (sel <= 5)      d = 0;
      else if (sel <= 7) d = $urandom_range(1, 3);
      else if (sel == 8) d = $urandom_range(TO - 3, TO - 1);
      else begin
        d     = 0;
        stuck = 1'b1;
      end
      apply_stimulus(d, stuck);
    end

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
    $finish;
  end

endmodule
